// File: rtl/register_file.sv
// register_file: multi-port architectural register array
// with a per-entry busy scoreboard and optional write bypass.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iWrite,
  input  logic [AW-1:0]           iWrAddr,
  input  logic [WIDTH-1:0]        iWrData,
  input  logic                    iSetBusy,
  input  logic [AW-1:0]           iBusyAddr,
  input  logic [N_READ*AW-1:0]    iRdAddr,
  output logic [N_READ*WIDTH-1:0] oRdData,
  output logic [N_READ-1:0]       oBusy
);

  localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
  localparam bit ZR  = (ZERO_REG != 0);
  localparam bit BYP = (BYPASS != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;

  logic wr_in;
  logic wr_ok;
  logic bs_in;
  logic bs_ok;

  // Qualify write and busy-set: in range, not the hardwired zero entry.
  always_comb begin
    wr_in = ({1'b0, iWrAddr} < DEPTH_V);
    bs_in = ({1'b0, iBusyAddr} < DEPTH_V);
    wr_ok = iWrite && wr_in
            && !(ZR && (iWrAddr == '0));
    bs_ok = iSetBusy && bs_in
            && !(ZR && (iBusyAddr == '0));
  end

  // Storage update; a new producer's busy-set overrides the
  // retiring write's clear when both hit the same entry.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[iWrAddr]  <= iWrData;
        busy[iWrAddr] <= 1'b0;
      end
      if (bs_ok) begin
        busy[iBusyAddr] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             ra_in;
    logic             ra_ok;
    logic             hit_wr;
    logic             hit_bs;
    logic [WIDTH-1:0] d;
    logic             b;

    assign ra = iRdAddr[p*AW +: AW];

    // Port read: range/zero masking, then bypass or stored entry.
    always_comb begin
      d      = '0;
      b      = 1'b0;
      ra_in  = ({1'b0, ra} < DEPTH_V);
      ra_ok  = ra_in && !(ZR && (ra == '0));
      hit_wr = BYP && wr_ok && (iWrAddr == ra);
      hit_bs = bs_ok && (iBusyAddr == ra);
      if (!iRst && ra_ok) begin
        if (hit_wr) begin
          d = iWrData;
          b = hit_bs ? busy[ra] : 1'b0;
        end else begin
          d = mem[ra];
          b = busy[ra];
        end
      end
    end

    assign oRdData[p*WIDTH +: WIDTH] = d;
    assign oBusy[p] = b;
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: two configurations of register_file
// driven by shared stimulus, checked against an array model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        wr;
  logic        sb;
  logic [4:0]  wa;
  logic [4:0]  ba;
  logic [31:0] wd;
  logic [4:0]  ra0, ra1, ra2;

  logic [63:0] dA;
  logic [1:0]  bA;
  logic [95:0] dB;
  logic [2:0]  bB;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] mem [2][32];
  logic        bsy [2][32];

  register_file #(
    .WIDTH(32), .DEPTH(32), .N_READ(2),
    .ZERO_REG(1), .BYPASS(1)
  ) u_a (
    .iClk(clk), .iRst(rst),
    .iWrite(wr), .iWrAddr(wa), .iWrData(wd),
    .iSetBusy(sb), .iBusyAddr(ba),
    .iRdAddr({ra1, ra0}),
    .oRdData(dA), .oBusy(bA)
  );

  register_file #(
    .WIDTH(32), .DEPTH(24), .N_READ(3),
    .ZERO_REG(0), .BYPASS(0)
  ) u_b (
    .iClk(clk), .iRst(rst),
    .iWrite(wr), .iWrAddr(wa), .iWrData(wd),
    .iSetBusy(sb), .iBusyAddr(ba),
    .iRdAddr({ra2, ra1, ra0}),
    .oRdData(dB), .oBusy(bB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Config 0: DEPTH 32, zero reg, bypass. Config 1: DEPTH 24, neither.
  function automatic int dep(input int c);
    return (c == 0) ? 32 : 24;
  endfunction

  function automatic bit legal(input int c, input logic [4:0] a);
    return (int'(a) < dep(c)) && !((c == 0) && (a == 5'd0));
  endfunction

  function automatic void model_rd(input int c,
                                   input logic [4:0] a,
                                   output logic [31:0] d,
                                   output logic b);
    d = '0;
    b = 1'b0;
    if (rst || !legal(c, a)) return;
    if ((c == 0) && wr && legal(c, wa) && (wa == a)) begin
      d = wd;
      b = (sb && (ba == a)) ? bsy[c][a] : 1'b0;
    end else begin
      d = mem[c][a];
      b = bsy[c][a];
    end
  endfunction

  // Reference state: clears on reset, writes then busy-sets.
  always @(posedge clk or posedge rst) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          mem[c][i] <= '0;
          bsy[c][i] <= 1'b0;
        end
      end else begin
        if (wr && legal(c, wa)) begin
          mem[c][wa] <= wd;
          if (!(sb && legal(c, ba) && ba == wa))
            bsy[c][wa] <= 1'b0;
        end
        if (sb && legal(c, ba))
          bsy[c][ba] <= 1'b1;
      end
    end
  end

  // Every cycle: all ports of both instances against the model.
  always @(negedge clk) begin
    logic [31:0] ed, ad;
    logic        eb, ab;
    logic [4:0]  a;
    #1;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < ((c == 0) ? 2 : 3); p++) begin
        a = (p == 0) ? ra0 : (p == 1) ? ra1 : ra2;
        model_rd(c, a, ed, eb);
        ad = (c == 0) ? dA[p*32 +: 32] : dB[p*32 +: 32];
        ab = (c == 0) ? bA[p] : bB[p];
        chk($sformatf("c%0d.p%0d.data", c, p), ad, ed);
        chk($sformatf("c%0d.p%0d.busy", c, p),
            {31'd0, ab}, {31'd0, eb});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    wr = 1'b0;
    sb = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr = 0; sb = 0; wa = 0; ba = 0; wd = 0;
    ra0 = 0; ra1 = 0; ra2 = 0;
    look();
    chk("rst.a0", dA[31:0], 32'h0);
    chk("rst.b0", dB[31:0], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    wr = 1; wa = 5; wd = 32'h11;
    tick();
    wd = 32'hDEADBEEF; ra0 = 5; ra1 = 5;
    #2;
    rst = 1'b1;
    look();
    chk("midrst.a0", dA[31:0], 32'h0);
    chk("midrst.a1", dA[63:32], 32'h0);
    chk("midrst.b0", dB[31:0], 32'h0);
    tick();
    rst = 1'b0;
    idle();
    look();
    chk("postrst.a5", dA[31:0], 32'h0);
    chk("postrst.b5", dB[31:0], 32'h0);

    tick();
    wr = 1; wa = 7; wd = 32'h12345678;
    tick();
    wa = 31; wd = 32'hCAFEF00D; ra0 = 7; ra1 = 31;
    tick();
    idle();
    look();
    chk("rd.a7", dA[31:0], 32'h12345678);
    chk("rd.a31", dA[63:32], 32'hCAFEF00D);
    chk("rd.b7", dB[31:0], 32'h12345678);
    chk("range.b31", dB[63:32], 32'h0);
    tick();
    ra1 = 7;
    look();
    chk("dual.a0", dA[31:0], 32'h12345678);
    chk("dual.a1", dA[63:32], 32'h12345678);

    tick();
    wr = 1; wa = 0; wd = 32'hFFFFFFFF;
    sb = 1; ba = 0; ra0 = 0;
    tick();
    idle();
    look();
    chk("zero.a.d", dA[31:0], 32'h0);
    chk("zero.a.b", {31'd0, bA[0]}, 32'h0);
    chk("zero.b.d", dB[31:0], 32'hFFFFFFFF);
    chk("zero.b.b", {31'd0, bB[0]}, 32'h1);

    tick();
    wr = 1; wa = 3; wd = 32'h1;
    tick();
    wd = 32'hAB; ra0 = 3;
    look();
    chk("byp.a", dA[31:0], 32'hAB);
    chk("nobyp.b", dB[31:0], 32'h1);
    tick();
    idle();
    look();
    chk("late.b", dB[31:0], 32'hAB);

    tick();
    sb = 1; ba = 9; ra0 = 9;
    tick();
    idle();
    look();
    chk("busy.a", {31'd0, bA[0]}, 32'h1);
    chk("busy.b", {31'd0, bB[0]}, 32'h1);
    tick();
    wr = 1; wa = 9; wd = 32'h55;
    look();
    chk("clr.a", {31'd0, bA[0]}, 32'h0);
    chk("clr.b", {31'd0, bB[0]}, 32'h1);
    tick();
    idle();
    look();
    chk("clr2.b", {31'd0, bB[0]}, 32'h0);
    tick();
    wr = 1; wa = 9; wd = 32'h55; sb = 1; ba = 9;
    tick();
    idle();
    look();
    chk("both.a.d", dA[31:0], 32'h55);
    chk("both.a.b", {31'd0, bA[0]}, 32'h1);
    chk("both.b.b", {31'd0, bB[0]}, 32'h1);

    tick();
    wr = 1; wa = 28; wd = 32'h77; ra0 = 28;
    tick();
    idle();
    look();
    chk("oor.b.d", dB[31:0], 32'h0);
    chk("oor.b.b", {31'd0, bB[0]}, 32'h0);
    chk("oor.a.d", dA[31:0], 32'h77);

    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 149) == 0);
      wr  = $urandom_range(0, 1) == 1;
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      sb  = $urandom_range(0, 3) == 0;
      ba  = ($urandom_range(0, 3) == 0)
            ? wa : 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 2) == 0)
            ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0)
            ? ba : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0)
            ? ra0 : 5'($urandom_range(0, 31));
    end

    tick();
    idle();
    rst = 1'b0;
    look();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
